// File: rtl/ysyx_25010008_ifu_prefetch_if.sv
// Read-only AXI-lite style bus between the prefetching IFU and instruction memory.
//   master (IFU):    drives araddr/arvalid/rready, samples arready/rdata/rresp/rvalid
//   slave  (memory): the mirror image
interface ysyx_25010008_ifu_prefetch_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] araddr;
  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (output araddr, arvalid, rready,
                  input  arready, rdata, rresp, rvalid);
  modport slave  (input  araddr, arvalid, rready,
                  output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/ysyx_25010008_ifu_prefetch.sv
// Prefetching instruction fetch unit.
// Issues sequential reads with up to MAX_OUTSTANDING requests in flight and
// buffers returned words in an in-order queue of QDEPTH entries feeding decode.
// A redirect flushes the queue and restarts fetch; responses to requests issued
// before the redirect are counted in 'drop' and discarded on arrival.
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   redirect_valid/_pc    one-cycle flush + new fetch address (bits [1:0] ignored)
//   bus (master)          AR/R read channels
//   inst_valid/_ready     decode handshake on the queue head
//   inst, inst_pc         head word and its address
//   inst_fault            head fetch returned a nonzero rresp
//   queue_count           occupied queue entries
module ysyx_25010008_ifu_prefetch #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(32'h2000_0000),
  parameter int              QDEPTH          = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  ysyx_25010008_ifu_prefetch_if.master bus,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [XLEN-1:0]         inst,
  output logic [XLEN-1:0]         inst_pc,
  output logic                    inst_fault,
  output logic [$clog2(QDEPTH):0] queue_count
);
  localparam int QAW = $clog2(QDEPTH);
  localparam int CW  = QAW + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
    logic            fault;
  } entry_t;

  logic [XLEN-1:0] fetch_pc, fetch_nxt, araddr_q, araddr_nxt;
  logic            arvalid_q, arvalid_nxt, stale_q, stale_nxt;
  logic [OW-1:0]   out_cnt, out_nxt, drop_cnt, drop_nxt;
  logic [CW-1:0]   q_cnt, cnt_nxt;
  logic [QAW-1:0]  q_wr, q_rd;
  logic [PW-1:0]   pcf_wr, pcf_rd;
  logic [MAX_OUTSTANDING-1:0][XLEN-1:0] pcf;   // PCs of accepted, unanswered requests
  entry_t [QDEPTH-1:0] q;
  logic            ar_fire, ar_stall, r_fire, keep, deq, can_issue;
  logic            unused_lo;

  function automatic logic [PW-1:0] pinc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign unused_lo   = ^redirect_pc[1:0];
  assign bus.araddr  = araddr_q;
  assign bus.arvalid = arvalid_q;
  // Credits reserve a queue slot per request, so the queue can always absorb a response.
  assign bus.rready  = 1'b1;

  assign ar_fire  = arvalid_q &  bus.arready;
  assign ar_stall = arvalid_q & ~bus.arready;
  assign r_fire   = bus.rvalid;
  assign deq      = inst_valid & inst_ready;
  assign keep     = r_fire & (drop_cnt == '0) & ~redirect_valid;

  always_comb begin
    out_nxt = out_cnt + OW'(ar_fire) - OW'(r_fire);
    if (redirect_valid) begin
      cnt_nxt   = '0;
      // Everything still unanswered is pre-redirect, including a stalled AR.
      drop_nxt  = out_nxt + OW'(ar_stall);
      fetch_nxt = {redirect_pc[XLEN-1:2], 2'b00};
      stale_nxt = ar_stall;
    end else begin
      cnt_nxt   = q_cnt + CW'(keep) - CW'(deq);
      drop_nxt  = drop_cnt - OW'(r_fire && (drop_cnt != '0));
      // A stale AR finishing must not advance the redirected fetch_pc.
      fetch_nxt = (ar_fire && !stale_q) ? fetch_pc + XLEN'(4) : fetch_pc;
      stale_nxt = stale_q & ~ar_fire;
    end
    can_issue = (32'(out_nxt) < MAX_OUTSTANDING) &&
                (32'(out_nxt) + 32'(cnt_nxt) < QDEPTH);
    if (ar_stall) begin
      arvalid_nxt = 1'b1;
      araddr_nxt  = araddr_q;
    end else begin
      arvalid_nxt = can_issue;
      araddr_nxt  = fetch_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      araddr_q  <= RESET_PC;
      arvalid_q <= 1'b0;
      stale_q   <= 1'b0;
      out_cnt   <= '0;
      drop_cnt  <= '0;
      q_cnt     <= '0;
      q_wr      <= '0;
      q_rd      <= '0;
      pcf_wr    <= '0;
      pcf_rd    <= '0;
      pcf       <= '0;
      q         <= '0;
    end else begin
      fetch_pc  <= fetch_nxt;
      araddr_q  <= araddr_nxt;
      arvalid_q <= arvalid_nxt;
      stale_q   <= stale_nxt;
      out_cnt   <= out_nxt;
      drop_cnt  <= drop_nxt;
      q_cnt     <= cnt_nxt;
      if (ar_fire) begin
        pcf[pcf_wr] <= araddr_q;
        pcf_wr      <= pinc(pcf_wr);
      end
      // The PC FIFO pops on every response, dropped or not, to stay aligned.
      if (r_fire) pcf_rd <= pinc(pcf_rd);
      if (redirect_valid) begin
        q_wr <= '0;
        q_rd <= '0;
      end else begin
        if (keep) begin
          q[q_wr] <= {bus.rdata, pcf[pcf_rd], |bus.rresp};
          q_wr    <= q_wr + QAW'(1);
        end
        if (deq) q_rd <= q_rd + QAW'(1);
      end
    end
  end

  assign inst_valid  = (q_cnt != '0);
  assign inst        = q[q_rd].word;
  assign inst_pc     = q[q_rd].pc;
  assign inst_fault  = q[q_rd].fault;
  assign queue_count = q_cnt;
endmodule

// File: doc/ysyx_25010008_ifu_prefetch.md
Name: ysyx_25010008_ifu_prefetch

Overview:
Parametrised instruction fetch unit that replaces the single-request fetch/decode handshake with a prefetching front end. It issues sequential fetch requests on an AXI-lite-style read address/data pair, keeping up to MAX_OUTSTANDING requests in flight. Returned words are buffered in an in-order instruction queue of depth QDEPTH, which feeds decode through a valid/ready handshake. A redirect from execute/writeback flushes the queue and restarts fetch at the new PC. Responses for requests issued before the redirect are discarded.

Parameters:
XLEN, 32, address and instruction width
RESET_PC, 32'h2000_0000, first fetch address after reset
QDEPTH, 4, instruction queue entries; power of two, at least 2
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered read requests; 1 to QDEPTH

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
redirect_valid  input  1  one-cycle pulse: flush and refetch from redirect_pc
redirect_pc  input  XLEN  new fetch address; bits [1:0] are ignored and treated as 0
araddr  output  XLEN  read request address
arvalid  output  1  read request valid
arready  input  1  read request accepted
rdata  input  XLEN  read data
rresp  input  2  read response; nonzero means error
rvalid  input  1  read data valid
rready  output  1  read data ready
inst_valid  output  1  queue head is valid
inst_ready  input  1  decode accepts the head
inst  output  XLEN  head instruction word
inst_pc  output  XLEN  head instruction address
inst_fault  output  1  head fetch returned nonzero rresp
queue_count  output  $clog2(QDEPTH)+1  occupied queue entries, for debug and DPI

Behaviour:
- Reset, synchronous: fetch_pc=RESET_PC, arvalid=0, araddr=RESET_PC, rready=1, queue empty, inst_valid=0, inst/inst_pc=0, inst_fault=0, outstanding=0, drop=0, queue_count=0. Reset mid-transaction abandons everything. No response is consumed in the reset cycle.
- Credits: a new request may be presented only when outstanding < MAX_OUTSTANDING and outstanding + queue_count < QDEPTH. This guarantees the queue never overflows, so rready is held at 1 outside reset.
- AR channel:
  - When credits allow, drive arvalid=1 with araddr=fetch_pc.
  - Once arvalid is asserted, arvalid and araddr stay stable until arready.
  - On handshake: outstanding++, fetch_pc += 4 (wraps mod 2^XLEN). Back-to-back requests are allowed in consecutive cycles.
- R channel: responses return in order.
  - If drop > 0, the response is discarded and drop-- (outstanding-- as well).
  - Otherwise enqueue {rdata, pc_of_request, rresp!=0} and outstanding--. The request PC comes from a small in-flight PC FIFO of depth MAX_OUTSTANDING.
- Latency: a response accepted in cycle N is visible as inst_valid in cycle N+1. A response arriving into an empty queue gives a first-word latency of 1 cycle after rvalid.
- Queue: inst/inst_pc/inst_fault show the head while inst_valid=1. Dequeue happens on inst_valid&&inst_ready. Enqueue and dequeue in the same cycle leave the count unchanged. Pointers wrap at QDEPTH.
- Redirect (cycle R), highest priority over normal updates in R:
  - Queue flushed; inst_valid=0 in R+1. A dequeue handshake in R still counts as consumed.
  - Any response accepted in R is discarded.
  - drop is set to the number of requests still unanswered after R, including an AR handshaking in R.
  - fetch_pc = {redirect_pc[XLEN-1:2],2'b00}.
- AR pending at redirect: if arvalid=1 and arready=0 in R, the stale request stays asserted unchanged until accepted and is counted in drop. The first redirected request follows it.
- Redirect while drop > 0 adds the new unanswered requests to drop; drop never exceeds MAX_OUTSTANDING.
- Error response: the entry is enqueued normally with inst_fault=1, and fetch continues sequentially. Decode raises the exception.
- Decode never sees an instruction from a pre-redirect stream.

Test Plan:
- Reset then zero-wait memory (arready=1, rvalid one cycle after AR), inst_ready=1 -> araddr sequence 0x2000_0000, 0x2000_0004, 0x2000_0008…; inst_pc matches in order, one inst per cycle at steady state with MAX_OUTSTANDING=2.
- inst_ready=0 with QDEPTH=4 -> exactly 4 ARs accepted, then arvalid=0; queue_count=4, no response lost. Release inst_ready -> fetch resumes at 0x2000_0010.
- Two requests in flight (0x2000_0000, 0x2000_0004), pulse redirect_pc=0x8000_0102 -> both responses dropped. Next araddr=0x8000_0100, and the first inst_pc after the redirect is 0x8000_0100.
- arready=0 while arvalid for 0x2000_0008, redirect to 0x3000_0000 -> araddr holds 0x2000_0008 until accepted, and its data is dropped. The next araddr is 0x3000_0000.
- rresp=2'b10 on the response for 0x2000_0004 -> that entry has inst_fault=1 and the neighbouring entries have inst_fault=0. The next fetch is 0x2000_0008.
- Assert reset for one cycle mid-burst with responses pending -> all outputs return to reset values, and the next AR is 0x2000_0000.
